// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - step-key operand/opcode sequencer wrapping a combinational ALU
//
// Collects operand A, operand B and a 3-bit opcode from the switches, one
// step-key rising edge per field. It pulses alu_en for the single EXEC cycle,
// latches the ALU result and flags for display, and counts completed operations.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   sw[N-1:0]         switch data (A, B, or opcode on sw[2:0])
//   step              debounced step key (level); rising edge advances
//   abort             synchronous abort back to IDLE (level)
//   alu_en/op/a/b     drive to the combinational ALU
//   alu_result/carry/overflow/zero   ALU outputs, sampled at the end of EXEC
//   res_q, carry_q, ovf_q, zero_q, res_valid   latched display values
//   stage[2:0]        current state encoding for the LEDs
//   op_count          wrap-around count of completed operations
module alu_operand_sequencer #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sw,
  input  logic             step,
  input  logic             abort,
  output logic             alu_en,
  output logic [2:0]       alu_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic [N-1:0]     res_q,
  output logic             carry_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             res_valid,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    GET_OP = 3'd3,
    EXEC   = 3'd4,
    SHOW   = 3'd5
  } state_t;

  state_t state, next_state;
  logic   step_d;
  logic   rise;
  logic   load_a, load_b, load_op;
  logic   capture, clear_valid;

  // step_d follows step every cycle, so a held key yields one edge and an
  // edge that lands in EXEC is consumed rather than deferred.
  assign rise  = step & ~step_d;
  assign stage = state;

  always_comb begin
    next_state  = state;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   if (rise) next_state = GET_A;
        GET_A:  if (rise) begin load_a = 1'b1; next_state = GET_B; end
        GET_B:  if (rise) begin load_b = 1'b1; next_state = GET_OP; end
        GET_OP: if (rise) begin load_op = 1'b1; next_state = EXEC; end
        EXEC: begin
          capture    = 1'b1;
          next_state = SHOW;
        end
        SHOW:   if (rise) begin clear_valid = 1'b1; next_state = GET_A; end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_d    <= 1'b0;
      alu_en    <= 1'b0;
      alu_op    <= 3'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      state  <= next_state;
      step_d <= step;
      // Registered enable: high exactly while the state register holds EXEC.
      alu_en <= (next_state == EXEC);
      if (load_a)  alu_a  <= sw;
      if (load_b)  alu_b  <= sw;
      if (load_op) alu_op <= sw[2:0];
      if (capture) begin
        res_q     <= alu_result;
        carry_q   <= alu_carry;
        ovf_q     <= alu_overflow;
        zero_q    <= alu_zero;
        res_valid <= 1'b1;
        op_count  <= op_count + CNT_W'(1);
      end else if (clear_valid || abort) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer
module tb_alu_operand_sequencer;
  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     sw;
  logic             step;
  logic             abort;
  logic             alu_en;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [N-1:0]     alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_zero;
  logic [N-1:0]     res_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             res_valid;
  logic [2:0]       stage;
  logic [CNT_W-1:0] op_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .step(step), .abort(abort),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .res_q(res_q), .carry_q(carry_q), .ovf_q(ovf_q), .zero_q(zero_q),
    .res_valid(res_valid), .stage(stage), .op_count(op_count)
  );

  // Reference ALU: returns {carry, overflow, zero, result}.
  function automatic logic [N+2:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[N-1:0]; c = s[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        r = s[N-1:0]; c = s[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      default: r = (a == b) ? N'(1) : N'(0);
    endcase
    return {c, v, (r == '0), r};
  endfunction

  assign {alu_carry, alu_overflow, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: stage number plus the registers a user sees.
  int         m_state = 0;
  bit         m_init  = 0;
  bit         m_sd, m_rise;
  logic [N-1:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  bit         m_c, m_v, m_z, m_valid, m_en;
  int         m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; m_state = 0; m_sd = 0; m_a = '0; m_b = '0; m_op = '0;
      m_res = '0; m_c = 0; m_v = 0; m_z = 0; m_valid = 0; m_cnt = 0; m_en = 0;
    end else if (m_init) begin
      m_rise = step && !m_sd;
      m_sd   = step;
      if (abort) begin
        m_state = 0; m_valid = 0;
      end else if (m_state == 4) begin
        {m_c, m_v, m_z, m_res} = alu_f(m_a, m_b, m_op);
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_state = 5;
      end else if (m_rise) begin
        case (m_state)
          0: m_state = 1;
          1: begin m_a = sw; m_state = 2; end
          2: begin m_b = sw; m_state = 3; end
          3: begin m_op = sw[2:0]; m_state = 4; end
          default: begin m_valid = 0; m_state = 1; end
        endcase
      end
      m_en = (m_state == 4);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("stage",     int'(stage),     m_state);
      check("alu_en",    int'(alu_en),    int'(m_en));
      check("alu_a",     int'(alu_a),     int'(m_a));
      check("alu_b",     int'(alu_b),     int'(m_b));
      check("alu_op",    int'(alu_op),    int'(m_op));
      check("res_q",     int'(res_q),     int'(m_res));
      check("carry_q",   int'(carry_q),   int'(m_c));
      check("ovf_q",     int'(ovf_q),     int'(m_v));
      check("zero_q",    int'(zero_q),    int'(m_z));
      check("res_valid", int'(res_valid), int'(m_valid));
      check("op_count",  int'(op_count),  m_cnt);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [N-1:0] v);
    sw = v; step = 1'b1; tick;
    step = 1'b0; sw = N'($urandom); tick;
  endtask

  // From GET_A: load A, B, opcode; checks the EXEC cycle, ends in SHOW.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    press(a);
    press(b);
    sw = '0; sw[2:0] = op; step = 1'b1; tick;
    check("exec_stage", int'(stage), 4);
    check("exec_en", int'(alu_en), 1);
    step = 1'b0; sw = N'($urandom); tick;
    check("show_stage", int'(stage), 5);
    check("show_en", int'(alu_en), 0);
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; step = 1'b0; abort = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    check("rst_stage", int'(stage), 0);
    check("rst_res", int'(res_q), 0);
    check("rst_cnt", int'(op_count), 0);
    check("rst_en", int'(alu_en), 0);
    tick;
    check("idle_hold", int'(stage), 0);

    press(4'b0000);
    check("to_get_a", int'(stage), 1);

    do_op(4'b0011, 4'b0100, 3'b000);
    check("add_res", int'(res_q), 7);
    check("add_c", int'(carry_q), 0);
    check("add_v", int'(ovf_q), 0);
    check("add_z", int'(zero_q), 0);
    check("add_valid", int'(res_valid), 1);
    check("add_cnt", int'(op_count), 1);
    press(4'b0000);
    check("show_clear", int'(res_valid), 0);

    do_op(4'b0111, 4'b1000, 3'b001);
    check("sub_res", int'(res_q), 15);
    check("sub_v", int'(ovf_q), 1);
    check("sub_c", int'(carry_q), 0);
    check("sub_z", int'(zero_q), 0);
    press(4'b0000);

    do_op(4'b1000, 4'b0001, 3'b110);
    check("lt_res", int'(res_q), 1);
    press(4'b0000);

    do_op(4'b0101, 4'b0101, 3'b111);
    check("eq_res", int'(res_q), 1);
    check("eq_z", int'(zero_q), 0);
    check("eq_cnt", int'(op_count), 4);
    press(4'b0000);

    // Abort in GET_B keeps the captured operand.
    press(4'b0101);
    abort = 1'b1; tick; abort = 1'b0;
    check("abort_b_stage", int'(stage), 0);
    check("abort_b_a", int'(alu_a), 5);
    press(4'b0000);

    // Abort during EXEC suppresses capture and counting.
    press(4'b0010);
    press(4'b0011);
    sw = '0; step = 1'b1; tick;
    check("abort_e_in_exec", int'(stage), 4);
    abort = 1'b1; step = 1'b0; tick; abort = 1'b0;
    check("abort_e_stage", int'(stage), 0);
    check("abort_e_valid", int'(res_valid), 0);
    check("abort_e_cnt", int'(op_count), 4);
    check("abort_e_res", int'(res_q), 1);
    press(4'b0000);

    // 252 more operations bring the count to 256, wrapping to 0.
    for (int i = 0; i < 252; i++) begin
      do_op(N'($urandom), N'($urandom), 3'($urandom));
      press(4'b0000);
    end
    check("wrap_cnt", int'(op_count), 0);

    // Held step: one advance, and only the rise-cycle switch value is taken.
    sw = 4'b1001; step = 1'b1; tick;
    sw = 4'b0001;
    repeat (9) tick;
    step = 1'b0; tick;
    check("held_stage", int'(stage), 2);
    check("held_a", int'(alu_a), 9);

    // Reset wins over a simultaneous abort.
    abort = 1'b1; rst_n = 1'b0; tick;
    rst_n = 1'b1; abort = 1'b0;
    check("rst2_stage", int'(stage), 0);
    check("rst2_a", int'(alu_a), 0);
    check("rst2_res", int'(res_q), 0);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
